jt900h_intseq: RTL



---
 rtl/jt900h_intseq_pkg.sv | 21 ++
 rtl/jt900h_intarb.sv | 35 +++
 rtl/jt900h_intseq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/jt900h_intseq_pkg.sv
// Shared definitions for the JT900H interrupt acceptance sequencer.
package jt900h_intseq_pkg;

    typedef enum logic [2:0] {
        INT_IDLE,
        INT_PUSHPC,
        INT_PUSHSR,
        INT_VECRD,
        INT_COMMIT
    } int_state_e;

    localparam logic [1:0] WORD_SZ = 2'd1;
    localparam logic [1:0] LONG_SZ = 2'd2;
    localparam logic [2:0] LVL_NMI = 3'd7;

    // IFF mask loaded on entry: one above the accepted level, saturating at NMI
    function automatic logic [2:0] next_iff(input logic [2:0] lvl);
        return (lvl == LVL_NMI) ? LVL_NMI : lvl + 3'd1;
    endfunction

endpackage

// File: rtl/jt900h_intarb.sv
// Combinational interrupt arbiter: eligibility against the IFF mask and
// highest-level selection, lowest index winning ties.
module jt900h_intarb
    import jt900h_intseq_pkg::*;
#(
    parameter int unsigned NSRC = 4
) (
    input  logic [NSRC-1:0]   irq,
    input  logic [3*NSRC-1:0] irq_lvl,
    input  logic [2:0]        riff,
    output logic              valid,
    output logic [2:0]        index,
    output logic [2:0]        level
);

    logic [2:0] lvl_c;

    // Ascending scan; strict greater-than keeps the lowest index on a tie
    always_comb begin
        valid = 1'b0;
        index = '0;
        level = '0;
        lvl_c = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            lvl_c = irq_lvl[3*i +: 3];
            if (irq[i] && (lvl_c != 3'd0) && ((lvl_c >= riff) || (lvl_c == LVL_NMI))
                && (!valid || (lvl_c > level))) begin
                valid = 1'b1;
                index = i[2:0];
                level = lvl_c;
            end
        end
    end

endmodule

// File: rtl/jt900h_intseq.sv
// Interrupt acceptance sequencer: pushes PC and SR, fetches the vector,
// then pulses register-file load strobes and the source acknowledge.
module jt900h_intseq
    import jt900h_intseq_pkg::*;
#(
    parameter int unsigned NSRC  = 4,
    parameter logic [23:0] VBASE = 24'hFFFF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic [NSRC-1:0]   irq,
    input  logic [3*NSRC-1:0] irq_lvl,
    input  logic [8*NSRC-1:0] irq_vec,
    input  logic              insn_end,
    input  logic [2:0]        riff,
    input  logic [31:0]       xsp,
    input  logic [23:0]       pc,
    input  logic [15:0]       sr,
    output logic              busy,
    output logic [NSRC-1:0]   ack,
    output logic [23:0]       bus_addr,
    output logic [31:0]       bus_dout,
    output logic [1:0]        bus_wsz,
    output logic              bus_we,
    output logic              bus_rd,
    input  logic              bus_ok,
    input  logic [31:0]       bus_din,
    output logic              xsp_ld,
    output logic [31:0]       xsp_nx,
    output logic              pc_ld,
    output logic [23:0]       pc_nx,
    output logic              iff_ld,
    output logic [2:0]        iff_nx
);

    int_state_e  state_q, state_d;
    logic [2:0]  win_q, win_d;
    logic [2:0]  lvl_q, lvl_d;
    logic [7:0]  vec_q, vec_d;
    logic [23:0] pc_q, pc_d;
    logic [15:0] sr_q, sr_d;
    logic [31:0] xsp_q, xsp_d;
    logic [23:0] pcn_q, pcn_d;

    logic        arb_valid;
    logic [2:0]  arb_index;
    logic [2:0]  arb_level;
    logic [7:0]  arb_vec;
    logic [31:0] xsp_m4;
    logic [31:0] xsp_m6;
    logic        unused_din;

    jt900h_intarb #(
        .NSRC (NSRC)
    ) u_arb (
        .irq     (irq),
        .irq_lvl (irq_lvl),
        .riff    (riff),
        .valid   (arb_valid),
        .index   (arb_index),
        .level   (arb_level)
    );

    assign xsp_m4     = xsp_q - 32'd4;
    assign xsp_m6     = xsp_q - 32'd6;
    assign pc_nx      = pcn_q;
    assign unused_din = ^bus_din[31:24];

    // Vector offset belonging to the current arbitration winner
    always_comb begin
        arb_vec = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (arb_index == i[2:0]) begin
                arb_vec = irq_vec[8*i +: 8];
            end
        end
    end

    // State and latched context; everything holds while cen is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INT_IDLE;
            win_q   <= '0;
            lvl_q   <= '0;
            vec_q   <= '0;
            pc_q    <= '0;
            sr_q    <= '0;
            xsp_q   <= '0;
            pcn_q   <= '0;
        end else if (cen) begin
            state_q <= state_d;
            win_q   <= win_d;
            lvl_q   <= lvl_d;
            vec_q   <= vec_d;
            pc_q    <= pc_d;
            sr_q    <= sr_d;
            xsp_q   <= xsp_d;
            pcn_q   <= pcn_d;
        end
    end

    // Next state, context capture and bus/strobe outputs decoded from state
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        lvl_d    = lvl_q;
        vec_d    = vec_q;
        pc_d     = pc_q;
        sr_d     = sr_q;
        xsp_d    = xsp_q;
        pcn_d    = pcn_q;
        busy     = (state_q != INT_IDLE);
        ack      = '0;
        bus_addr = '0;
        bus_dout = '0;
        bus_wsz  = '0;
        bus_we   = 1'b0;
        bus_rd   = 1'b0;
        xsp_ld   = 1'b0;
        xsp_nx   = '0;
        pc_ld    = 1'b0;
        iff_ld   = 1'b0;
        iff_nx   = '0;
        case (state_q)
            INT_IDLE: begin
                if (insn_end && arb_valid) begin
                    win_d   = arb_index;
                    lvl_d   = arb_level;
                    vec_d   = arb_vec;
                    pc_d    = pc;
                    sr_d    = sr;
                    xsp_d   = xsp;
                    state_d = INT_PUSHPC;
                end
            end
            INT_PUSHPC: begin
                bus_we   = 1'b1;
                bus_wsz  = LONG_SZ;
                bus_addr = xsp_m4[23:0];
                bus_dout = {8'd0, pc_q};
                if (bus_ok) state_d = INT_PUSHSR;
            end
            INT_PUSHSR: begin
                bus_we   = 1'b1;
                bus_wsz  = WORD_SZ;
                bus_addr = xsp_m6[23:0];
                bus_dout = {16'd0, sr_q};
                if (bus_ok) state_d = INT_VECRD;
            end
            INT_VECRD: begin
                bus_rd   = 1'b1;
                bus_wsz  = LONG_SZ;
                bus_addr = VBASE + {16'd0, vec_q};
                if (bus_ok) begin
                    pcn_d   = bus_din[23:0];
                    state_d = INT_COMMIT;
                end
            end
            INT_COMMIT: begin
                xsp_ld  = 1'b1;
                xsp_nx  = xsp_m6;
                pc_ld   = 1'b1;
                iff_ld  = 1'b1;
                iff_nx  = next_iff(lvl_q);
                for (int unsigned i = 0; i < NSRC; i++) begin
                    ack[i] = (win_q == i[2:0]);
                end
                state_d = INT_IDLE;
            end
            default: state_d = INT_IDLE;
        endcase
    end

endmodule
